// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates on issue, collects CDB results out of order, retires the head.
// Optional macro ROB_WB_BYPASS_EN lets a CDB result for the waiting head entry commit at the same edge.
module reorder_buffer #(
  parameter int RobSizeLog = 3,
  parameter int RdLength   = 4,
  parameter int DataLength = 31,
  parameter int PcLength   = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                is_empty_from_decoder,
  input  logic [PcLength:0]   pc_from_decoder,
  input  logic [RdLength:0]   rd_from_decoder,
  input  logic                is_valid_from_cdb,
  input  logic [PcLength:0]   pc_from_cdb,
  input  logic [DataLength:0] data_from_cdb,
  input  logic                is_exception_from_cdb,
  input  logic [PcLength:0]   target_pc_from_cdb,
  output logic                is_full_to_decoder,
  output logic                is_commit_to_rf,
  output logic                is_exception_to_rf,
  output logic [RdLength:0]   rd_to_rf,
  output logic [DataLength:0] data_to_rf,
  output logic [PcLength:0]   pc_to_rf,
  output logic [PcLength:0]   target_pc_to_fetch
);
  localparam int RobSize = 1 << RobSizeLog;
  typedef logic [RobSizeLog-1:0] ptr_t;
  typedef logic [RobSizeLog:0]   cnt_t;
  localparam cnt_t CntMax = cnt_t'(RobSize);
  localparam cnt_t CntThr = cnt_t'(RobSize - 1);

  logic [RobSize-1:0]  valid_q, ready_q, exc_q;
  logic [PcLength:0]   pc_q     [RobSize];
  logic [RdLength:0]   rd_q     [RobSize];
  logic [DataLength:0] data_q   [RobSize];
  logic [PcLength:0]   target_q [RobSize];
  ptr_t                head_q, tail_q;
  cnt_t                count_q;

  logic                commit_q, exc_out_q;
  logic [RdLength:0]   rd_out_q;
  logic [DataLength:0] data_out_q;
  logic [PcLength:0]   pc_out_q, target_out_q;

  logic                wb_hit;
  ptr_t                wb_idx;
  logic                alloc_en, commit_en, commit_exc;
  logic [DataLength:0] commit_data;
  logic [PcLength:0]   commit_target;

  // Scan youngest to oldest so the oldest matching in-flight entry wins.
  always_comb begin
    wb_hit = 1'b0;
    wb_idx = head_q;
    for (int i = RobSize - 1; i >= 0; i--) begin
      if (is_valid_from_cdb && valid_q[head_q + ptr_t'(i)] && !ready_q[head_q + ptr_t'(i)] &&
          pc_q[head_q + ptr_t'(i)] == pc_from_cdb) begin
        wb_hit = 1'b1;
        wb_idx = head_q + ptr_t'(i);
      end
    end
  end

  always_comb begin
    alloc_en      = !is_empty_from_decoder && (count_q < CntMax);
    commit_en     = valid_q[head_q] && ready_q[head_q];
    commit_exc    = exc_q[head_q];
    commit_data   = data_q[head_q];
    commit_target = target_q[head_q];
`ifdef ROB_WB_BYPASS_EN
    if (wb_hit && wb_idx == head_q) begin
      commit_en     = 1'b1;
      commit_exc    = is_exception_from_cdb;
      commit_data   = data_from_cdb;
      commit_target = target_pc_from_cdb;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      ready_q      <= '0;
      exc_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_q     <= 1'b0;
      exc_out_q    <= 1'b0;
      rd_out_q     <= '0;
      data_out_q   <= '0;
      pc_out_q     <= '0;
      target_out_q <= '0;
      for (int i = 0; i < RobSize; i++) begin
        pc_q[i]     <= '0;
        rd_q[i]     <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
    end else if (!rdy) begin
      commit_q  <= 1'b0;
      exc_out_q <= 1'b0;
    end else begin
      commit_q  <= commit_en;
      exc_out_q <= commit_en && commit_exc;
      if (commit_en) begin
        rd_out_q   <= rd_q[head_q];
        data_out_q <= commit_data;
        pc_out_q   <= pc_q[head_q];
      end
      if (commit_en && commit_exc) begin
        // Mispredict at the head: drop everything, including this cycle's issue and writeback.
        target_out_q <= commit_target;
        valid_q      <= '0;
        ready_q      <= '0;
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
      end else begin
        if (wb_hit) begin
          ready_q[wb_idx]  <= 1'b1;
          data_q[wb_idx]   <= data_from_cdb;
          exc_q[wb_idx]    <= is_exception_from_cdb;
          target_q[wb_idx] <= target_pc_from_cdb;
        end
        if (alloc_en) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          exc_q[tail_q]   <= 1'b0;
          pc_q[tail_q]    <= pc_from_decoder;
          rd_q[tail_q]    <= rd_from_decoder;
          tail_q          <= tail_q + 1'b1;
        end
        if (commit_en) begin
          valid_q[head_q] <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        case ({alloc_en, commit_en})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign is_full_to_decoder = (count_q >= CntThr);
  assign is_commit_to_rf    = commit_q;
  assign is_exception_to_rf = exc_out_q;
  assign rd_to_rf           = rd_out_q;
  assign data_to_rf         = data_out_q;
  assign pc_to_rf           = pc_out_q;
  assign target_pc_to_fetch = target_out_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        is_empty_from_decoder;
  logic [31:0] pc_from_decoder;
  logic [4:0]  rd_from_decoder;
  logic        is_valid_from_cdb;
  logic [31:0] pc_from_cdb;
  logic [31:0] data_from_cdb;
  logic        is_exception_from_cdb;
  logic [31:0] target_pc_from_cdb;
  logic        is_full_to_decoder;
  logic        is_commit_to_rf;
  logic        is_exception_to_rf;
  logic [4:0]  rd_to_rf;
  logic [31:0] data_to_rf;
  logic [31:0] pc_to_rf;
  logic [31:0] target_pc_to_fetch;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: in-flight entries oldest first, plus the expected registered outputs.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rdy;
    logic        exc;
    logic [31:0] data;
    logic [31:0] tgt;
  } ent_t;
  ent_t        mq[$];
  logic        m_commit, m_exc;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_pc, m_tgt;

  reorder_buffer dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .is_empty_from_decoder (is_empty_from_decoder),
    .pc_from_decoder       (pc_from_decoder),
    .rd_from_decoder       (rd_from_decoder),
    .is_valid_from_cdb     (is_valid_from_cdb),
    .pc_from_cdb           (pc_from_cdb),
    .data_from_cdb         (data_from_cdb),
    .is_exception_from_cdb (is_exception_from_cdb),
    .target_pc_from_cdb    (target_pc_from_cdb),
    .is_full_to_decoder    (is_full_to_decoder),
    .is_commit_to_rf       (is_commit_to_rf),
    .is_exception_to_rf    (is_exception_to_rf),
    .rd_to_rf              (rd_to_rf),
    .data_to_rf            (data_to_rf),
    .pc_to_rf              (pc_to_rf),
    .target_pc_to_fetch    (target_pc_to_fetch)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_commit = 0; m_exc = 0; m_rd = '0; m_data = '0; m_pc = '0; m_tgt = '0;
  endtask

  // Driver: apply one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic tick(input bit r, input bit iss, input logic [31:0] ipc, input logic [4:0] ird,
                      input bit cv, input logic [31:0] cpc, input logic [31:0] cd,
                      input bit ce, input logic [31:0] ct);
    ent_t e;
    rdy = r; is_empty_from_decoder = !iss; pc_from_decoder = ipc; rd_from_decoder = ird;
    is_valid_from_cdb = cv; pc_from_cdb = cpc; data_from_cdb = cd;
    is_exception_from_cdb = ce; target_pc_from_cdb = ct;
    @(posedge clk);
    m_commit = 0; m_exc = 0;
    if (r) begin
      if (mq.size() > 0 && mq[0].rdy) begin
        m_commit = 1; m_rd = mq[0].rd; m_data = mq[0].data; m_pc = mq[0].pc;
        if (mq[0].exc) begin
          m_exc = 1; m_tgt = mq[0].tgt;
          mq.delete();
        end
      end
      if (!m_exc) begin
        if (cv) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].rdy && mq[i].pc == cpc) begin
              e = mq[i]; e.rdy = 1; e.data = cd; e.exc = ce; e.tgt = ct; mq[i] = e;
              break;
            end
          end
        end
        if (iss && mq.size() < 8) mq.push_back('{pc: ipc, rd: ird, rdy: 1'b0, exc: 1'b0, data: '0, tgt: '0});
        if (m_commit) void'(mq.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle(input bit r = 1);
    tick(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (is_commit_to_rf !== 1'b0) $display("FAIL reset_commit got %0b want 0", is_commit_to_rf); else n_pass++;
    n_checks++; if (is_exception_to_rf !== 1'b0) $display("FAIL reset_exc got %0b want 0", is_exception_to_rf); else n_pass++;
    n_checks++; if (is_full_to_decoder !== 1'b0) $display("FAIL reset_full got %0b want 0", is_full_to_decoder); else n_pass++;
    n_checks++; if ({rd_to_rf, data_to_rf, pc_to_rf, target_pc_to_fetch} !== '0)
      $display("FAIL reset_data got rd=%h data=%h pc=%h tgt=%h want 0", rd_to_rf, data_to_rf, pc_to_rf, target_pc_to_fetch);
    else n_pass++;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_in_order();
    tick(1, 1, 32'h100, 5'd3, 0, 0, 0, 0, 0);
    tick(1, 1, 32'h104, 5'd4, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h104, 32'h55, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h100, 32'd7, 0, 0);
    n_checks++; if (is_commit_to_rf !== 1'b0) $display("FAIL in_order_early got commit %0b want 0", is_commit_to_rf); else n_pass++;
    idle();
    n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf} !== {1'b1, 5'd3, 32'd7, 32'h100})
      $display("FAIL in_order_first got c=%0b rd=%0d data=%h pc=%h want c=1 rd=3 data=7 pc=100", is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf);
    else n_pass++;
    idle();
    n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf} !== {1'b1, 5'd4, 32'h55, 32'h104})
      $display("FAIL in_order_second got c=%0b rd=%0d data=%h pc=%h want c=1 rd=4 data=55 pc=104", is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf);
    else n_pass++;
    idle();
    n_checks++; if (is_commit_to_rf !== 1'b0) $display("FAIL in_order_pulse got %0b want 0", is_commit_to_rf); else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] pend[$];
    int k, cyc;
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (is_full_to_decoder !== 1'b0) $display("FAIL full_early[%0d] got %0b want 0", i, is_full_to_decoder); else n_pass++;
      tick(1, 1, 32'h500 + 32'(4 * i), 5'(i + 1), 0, 0, 0, 0, 0);
    end
    n_checks++; if (is_full_to_decoder !== 1'b1) $display("FAIL full_at7 got %0b want 1", is_full_to_decoder); else n_pass++;
    tick(1, 0, 0, 0, 1, 32'h500, 32'hA0, 0, 0);
    n_checks++; if (is_full_to_decoder !== 1'b1) $display("FAIL full_hold got %0b want 1", is_full_to_decoder); else n_pass++;
    idle();
    n_checks++; if ({is_commit_to_rf, is_full_to_decoder} !== 2'b10)
      $display("FAIL full_release got commit=%0b full=%0b want 1 0", is_commit_to_rf, is_full_to_decoder);
    else n_pass++;
    // Fill to 8 via the slack slot, then one more issue that must be dropped.
    tick(1, 1, 32'h51C, 5'd8, 0, 0, 0, 0, 0);
    tick(1, 1, 32'h520, 5'd9, 0, 0, 0, 0, 0);
    tick(1, 1, 32'h5FC, 5'd10, 0, 0, 0, 0, 0);
    n_checks++; if (mq.size() != 8 || is_full_to_decoder !== 1'b1)
      $display("FAIL full_at8 got full=%0b model=%0d want full=1 model=8", is_full_to_decoder, mq.size());
    else n_pass++;
    for (int i = 0; i < mq.size(); i++) pend.push_back(mq[i].pc);
    pend.push_back(32'h5FC);
    cyc = 0;
    while ((pend.size() > 0 || mq.size() > 0) && cyc < 40) begin
      if (pend.size() > 0) begin
        k = $urandom_range(0, pend.size() - 1);
        tick(1, 0, 0, 0, 1, pend[k], $urandom, 0, 0);
        pend.delete(k);
      end else idle();
      n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf} !== {m_commit, m_rd, m_data, m_pc})
        $display("FAIL full_drain got c=%0b rd=%0d data=%h pc=%h want c=%0b rd=%0d data=%h pc=%h",
                 is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf, m_commit, m_rd, m_data, m_pc);
      else n_pass++;
      cyc++;
    end
    n_checks++; if (mq.size() != 0) $display("FAIL full_drain_timeout got %0d left want 0", mq.size()); else n_pass++;
    idle();
  endtask

  task automatic test_exception();
    tick(1, 1, 32'h200, 5'd5, 0, 0, 0, 0, 0);
    tick(1, 1, 32'h204, 5'd6, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h204, 32'd9, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h200, 32'h11, 1, 32'h300);
    tick(1, 1, 32'h208, 5'd8, 0, 0, 0, 0, 0);
    n_checks++; if ({is_commit_to_rf, is_exception_to_rf, target_pc_to_fetch, rd_to_rf, pc_to_rf} !==
                    {1'b1, 1'b1, 32'h300, 5'd5, 32'h200})
      $display("FAIL exc_pulse got c=%0b e=%0b tgt=%h rd=%0d pc=%h want c=1 e=1 tgt=300 rd=5 pc=200",
               is_commit_to_rf, is_exception_to_rf, target_pc_to_fetch, rd_to_rf, pc_to_rf);
    else n_pass++;
    n_checks++; if (is_full_to_decoder !== 1'b0) $display("FAIL exc_full got %0b want 0", is_full_to_decoder); else n_pass++;
    tick(1, 0, 0, 0, 1, 32'h208, 32'd5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({is_commit_to_rf, is_exception_to_rf} !== 2'b00)
        $display("FAIL exc_flushed[%0d] got c=%0b e=%0b want 0 0", i, is_commit_to_rf, is_exception_to_rf);
      else n_pass++;
      idle();
    end
  endtask

  task automatic test_loop();
    tick(1, 1, 32'h40, 5'd1, 0, 0, 0, 0, 0);
    tick(1, 1, 32'h40, 5'd2, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h40, 32'd1, 0, 0);
    idle();
    n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf} !== {1'b1, 5'd1, 32'd1})
      $display("FAIL loop_older got c=%0b rd=%0d data=%h want c=1 rd=1 data=1", is_commit_to_rf, rd_to_rf, data_to_rf);
    else n_pass++;
    idle();
    n_checks++; if (is_commit_to_rf !== 1'b0) $display("FAIL loop_younger_waits got %0b want 0", is_commit_to_rf); else n_pass++;
    tick(1, 0, 0, 0, 1, 32'h40, 32'd2, 0, 0);
    idle();
    n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf} !== {1'b1, 5'd2, 32'd2})
      $display("FAIL loop_younger got c=%0b rd=%0d data=%h want c=1 rd=2 data=2", is_commit_to_rf, rd_to_rf, data_to_rf);
    else n_pass++;
  endtask

  task automatic test_stall();
    tick(1, 1, 32'h80, 5'd7, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h80, 32'hAB, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 32'h84, 5'd9, 0, 0, 0, 0, 0);
      n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf} !== {1'b0, 5'd2, 32'd2})
        $display("FAIL stall[%0d] got c=%0b rd=%0d data=%h want c=0 rd=2 data=2", i, is_commit_to_rf, rd_to_rf, data_to_rf);
      else n_pass++;
    end
    idle();
    n_checks++; if ({is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf} !== {1'b1, 5'd7, 32'hAB, 32'h80})
      $display("FAIL stall_resume got c=%0b rd=%0d data=%h pc=%h want c=1 rd=7 data=ab pc=80", is_commit_to_rf, rd_to_rf, data_to_rf, pc_to_rf);
    else n_pass++;
    idle();
    n_checks++; if (is_commit_to_rf !== 1'b0) $display("FAIL stall_no_alloc got %0b want 0", is_commit_to_rf); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 5; i++) tick(1, 1, 32'h600 + 32'(4 * i), 5'(20 + i), 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1, 32'h600, 32'h99, 0, 0);
    n_checks++; if (is_full_to_decoder !== 1'b0 || mq.size() != 5)
      $display("FAIL midrun_pre got full=%0b model=%0d want 0 5", is_full_to_decoder, mq.size());
    else n_pass++;
    #2 rst = 1;
    #1;
    n_checks++; if ({is_commit_to_rf, is_exception_to_rf, is_full_to_decoder, rd_to_rf, data_to_rf, pc_to_rf, target_pc_to_fetch} !== '0)
      $display("FAIL midrun_reset got c=%0b e=%0b f=%0b rd=%0d data=%h pc=%h tgt=%h want all 0",
               is_commit_to_rf, is_exception_to_rf, is_full_to_decoder, rd_to_rf, data_to_rf, pc_to_rf, target_pc_to_fetch);
    else n_pass++;
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    tick(1, 0, 0, 0, 1, 32'h600, 32'h77, 0, 0);
    idle();
    n_checks++; if (is_commit_to_rf !== 1'b0) $display("FAIL midrun_cleared got %0b want 0", is_commit_to_rf); else n_pass++;
  endtask

  task automatic test_random();
    bit r, iss, cv, ce;
    logic [31:0] cpc;
    for (int c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 9) != 0);
      iss = ($urandom_range(0, 9) < 6);
      cv  = ($urandom_range(0, 9) < 7);
      ce  = ($urandom_range(0, 19) == 0);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) cpc = mq[$urandom_range(0, mq.size() - 1)].pc;
      else cpc = 32'(4 * $urandom_range(0, 7));
      tick(r, iss, 32'(4 * $urandom_range(0, 7)), 5'($urandom_range(0, 31)), cv, cpc, $urandom, ce, $urandom);
      n_checks++; if ({is_commit_to_rf, is_exception_to_rf, is_full_to_decoder} !== {m_commit, m_exc, mq.size() >= 7})
        $display("FAIL rand_ctrl[%0d] got c=%0b e=%0b f=%0b want c=%0b e=%0b f=%0b", c,
                 is_commit_to_rf, is_exception_to_rf, is_full_to_decoder, m_commit, m_exc, mq.size() >= 7);
      else n_pass++;
      n_checks++; if ({rd_to_rf, data_to_rf, pc_to_rf, target_pc_to_fetch} !== {m_rd, m_data, m_pc, m_tgt})
        $display("FAIL rand_data[%0d] got rd=%0d data=%h pc=%h tgt=%h want rd=%0d data=%h pc=%h tgt=%h", c,
                 rd_to_rf, data_to_rf, pc_to_rf, target_pc_to_fetch, m_rd, m_data, m_pc, m_tgt);
      else n_pass++;
    end
  endtask

  initial begin
    rdy = 1; is_empty_from_decoder = 1; pc_from_decoder = '0; rd_from_decoder = '0;
    is_valid_from_cdb = 0; pc_from_cdb = '0; data_from_cdb = '0;
    is_exception_from_cdb = 0; target_pc_from_cdb = '0;
    test_reset();
    test_in_order();
    test_full();
    test_exception();
    test_loop();
    test_stall();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
